branch_resolve_unit: RTL and testbench

Parametrised branch-decision block for the CPU's execute stage. It replaces the single zero-AND-branch decision with a full condition comparator (EQ/NE/signed/unsigned LT/GE), registers the result, and drives a multi-cycle pipeline flush. It also keeps saturating branch statistics for debug. It sits between the ALU operand path and the PC-select mux and fetch/decode flush controls.

---
 rtl/branch_resolve_unit.sv | 99 +++++++++
 tb/tb_branch_resolve_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: condition compare, registered PC-select pulse,
// multi-cycle fetch/decode flush, and saturating branch statistics.
module branch_resolve_unit #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 branch_en,
  input  logic [2:0]           cond,
  input  logic [WIDTH-1:0]     rs1_val,
  input  logic [WIDTH-1:0]     rs2_val,
  input  logic [WIDTH-1:0]     target_in,
  output logic                 taken_out,
  output logic [WIDTH-1:0]     target_out,
  output logic                 flush,
  output logic                 busy,
  output logic                 illegal_cond,
  output logic [CNT_WIDTH-1:0] stat_branches,
  output logic [CNT_WIDTH-1:0] stat_taken
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] flush_cnt;
  logic       accept;
  logic       cond_true;
  logic       reserved;

  assign accept = valid_in && branch_en && (state == IDLE);

  always_comb begin
    cond_true = 1'b0;
    reserved  = 1'b0;
    unique case (cond)
      3'b000:  cond_true = (rs1_val == rs2_val);
      3'b001:  cond_true = (rs1_val != rs2_val);
      3'b100:  cond_true = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  cond_true = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  cond_true = (rs1_val <  rs2_val);
      3'b111:  cond_true = (rs1_val >= rs2_val);
      default: reserved  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      flush_cnt     <= '0;
      taken_out     <= 1'b0;
      target_out    <= '0;
      flush         <= 1'b0;
      busy          <= 1'b0;
      illegal_cond  <= 1'b0;
      stat_branches <= '0;
      stat_taken    <= '0;
    end else begin
      taken_out    <= 1'b0;
      illegal_cond <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            illegal_cond <= reserved;
            if (stat_branches != '1)
              stat_branches <= stat_branches + 1'b1;
            if (cond_true) begin
              taken_out  <= 1'b1;
              target_out <= target_in;
              flush      <= 1'b1;
              busy       <= 1'b1;
              flush_cnt  <= FLUSH_LOAD;
              state      <= FLUSH;
              if (stat_taken != '1)
                stat_taken <= stat_taken + 1'b1;
            end
          end
        end
        FLUSH: begin
          // Inputs are ignored here; the exit edge drops flush/busy so the
          // following edge is the first accept opportunity.
          if (flush_cnt == '0) begin
            state <= IDLE;
            flush <= 1'b0;
            busy  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: default instance plus a small
// saturating-counter instance with single-cycle flush.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, branch_en;
  logic [2:0]  cond;
  logic [31:0] rs1_val, rs2_val, target_in;
  logic        taken_out, flush, busy, illegal_cond;
  logic [31:0] target_out;
  logic [15:0] stat_branches, stat_taken;

  logic        s_valid;
  logic [2:0]  s_cond;
  logic [31:0] s_rs1, s_rs2, s_tgt;
  logic        s_taken, s_flush, s_busy, s_illegal;
  logic [31:0] s_target_out;
  logic [1:0]  s_stat_b, s_stat_t;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(32), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .branch_en(branch_en),
    .cond(cond), .rs1_val(rs1_val), .rs2_val(rs2_val), .target_in(target_in),
    .taken_out(taken_out), .target_out(target_out), .flush(flush), .busy(busy),
    .illegal_cond(illegal_cond), .stat_branches(stat_branches),
    .stat_taken(stat_taken)
  );

  branch_resolve_unit #(.WIDTH(32), .FLUSH_CYCLES(1), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .valid_in(s_valid), .branch_en(1'b1),
    .cond(s_cond), .rs1_val(s_rs1), .rs2_val(s_rs2), .target_in(s_tgt),
    .taken_out(s_taken), .target_out(s_target_out), .flush(s_flush),
    .busy(s_busy), .illegal_cond(s_illegal), .stat_branches(s_stat_b),
    .stat_taken(s_stat_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] t);
    valid_in  = v;
    branch_en = v;
    cond      = c;
    rs1_val   = a;
    rs2_val   = b;
    target_in = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'b000, 0, 0, 0);
    s_valid = 1'b0; s_cond = 3'b000; s_rs1 = 0; s_rs2 = 0; s_tgt = 32'h80;
    tick(); tick();
    chk("rst_taken", {31'b0, taken_out}, 0);
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_target", target_out, 0);
    chk("rst_stat_b", {16'b0, stat_branches}, 0);
    rst = 1'b0;

    // 1: reset during the first flush cycle
    drive(1'b1, 3'b000, 5, 5, 32'h40);
    tick();
    chk("t1_taken", {31'b0, taken_out}, 1);
    chk("t1_flush", {31'b0, flush}, 1);
    chk("t1_target", target_out, 32'h40);
    chk("t1_stat_t", {16'b0, stat_taken}, 1);
    drive(1'b0, 3'b000, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1_rst_flush", {31'b0, flush}, 0);
    chk("t1_rst_busy", {31'b0, busy}, 0);
    chk("t1_rst_target", target_out, 0);
    chk("t1_rst_stat_b", {16'b0, stat_branches}, 0);
    chk("t1_rst_stat_t", {16'b0, stat_taken}, 0);

    // 2: signed LT taken, then unsigned LTU not taken
    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 1, 32'h100);
    tick();
    chk("t2_lt_taken", {31'b0, taken_out}, 1);
    chk("t2_lt_target", target_out, 32'h100);
    chk("t2_flush_c1", {31'b0, flush}, 1);
    drive(1'b0, 3'b000, 0, 0, 0);
    tick();
    chk("t2_taken_pulse", {31'b0, taken_out}, 0);
    chk("t2_flush_c2", {31'b0, flush}, 1);
    tick();
    chk("t2_flush_end", {31'b0, flush}, 0);
    chk("t2_busy_end", {31'b0, busy}, 0);
    drive(1'b1, 3'b110, 32'hFFFF_FFFF, 1, 32'h200);
    tick();
    chk("t2_ltu_taken", {31'b0, taken_out}, 0);
    chk("t2_ltu_flush", {31'b0, flush}, 0);
    chk("t2_stat_b", {16'b0, stat_branches}, 2);
    chk("t2_stat_t", {16'b0, stat_taken}, 1);
    chk("t2_target_hold", target_out, 32'h100);
    drive(1'b0, 3'b000, 0, 0, 0);

    // 3: not-taken NE back to back
    do_reset();
    drive(1'b1, 3'b001, 7, 7, 32'h300);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_taken", {31'b0, taken_out}, 0);
      chk("t3_flush", {31'b0, flush}, 0);
    end
    chk("t3_stat_b", {16'b0, stat_branches}, 3);
    chk("t3_target", target_out, 0);
    drive(1'b0, 3'b000, 0, 0, 0);

    // 4: busy masking, held BEQ accepted on the first non-busy cycle
    do_reset();
    drive(1'b1, 3'b111, 3, 2, 32'h200);
    tick();
    chk("t4_geu_taken", {31'b0, taken_out}, 1);
    drive(1'b1, 3'b000, 9, 9, 32'h300);
    tick();
    chk("t4_busy_c2", {31'b0, busy}, 1);
    chk("t4_ign_taken", {31'b0, taken_out}, 0);
    chk("t4_ign_stat_b", {16'b0, stat_branches}, 1);
    tick();
    chk("t4_busy_low", {31'b0, busy}, 0);
    chk("t4_ign_stat_b2", {16'b0, stat_branches}, 1);
    chk("t4_target_hold", target_out, 32'h200);
    tick();
    chk("t4_beq_taken", {31'b0, taken_out}, 1);
    chk("t4_beq_target", target_out, 32'h300);
    chk("t4_stat_b", {16'b0, stat_branches}, 2);
    chk("t4_stat_t", {16'b0, stat_taken}, 2);
    drive(1'b0, 3'b000, 0, 0, 0);
    tick(); tick();

    // 5: reserved cond, then signed GE
    do_reset();
    drive(1'b1, 3'b010, 1, 1, 32'h500);
    tick();
    chk("t5_illegal", {31'b0, illegal_cond}, 1);
    chk("t5_taken", {31'b0, taken_out}, 0);
    chk("t5_stat_b", {16'b0, stat_branches}, 1);
    chk("t5_stat_t", {16'b0, stat_taken}, 0);
    drive(1'b0, 3'b000, 0, 0, 0);
    tick();
    chk("t5_illegal_pulse", {31'b0, illegal_cond}, 0);
    drive(1'b1, 3'b101, 1, 32'hFFFF_FFFF, 32'h600);
    tick();
    chk("t5_ge_taken", {31'b0, taken_out}, 1);
    chk("t5_ge_illegal", {31'b0, illegal_cond}, 0);
    chk("t5_ge_target", target_out, 32'h600);
    drive(1'b0, 3'b000, 0, 0, 0);
    tick(); tick();

    // 6: saturating counters, single-cycle flush
    do_reset();
    s_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t6_taken", {31'b0, s_taken}, 1);
      chk("t6_flush_on", {31'b0, s_flush}, 1);
      chk("t6_stat_b", {30'b0, s_stat_b}, (k > 3) ? 3 : k);
      tick();
      chk("t6_flush_off", {31'b0, s_flush}, 0);
      chk("t6_busy_off", {31'b0, s_busy}, 0);
    end
    s_valid = 1'b0;
    chk("t6_sat_b", {30'b0, s_stat_b}, 3);
    chk("t6_sat_t", {30'b0, s_stat_t}, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
